// File: rtl/rand_event_gen_if.sv
// Event-generator interface: groups the random input, control levels,
// acknowledge and the event outputs of rand_event_gen.
//   rnd       : 8-bit pseudo-random value, changes every clock
//   enable    : level, 1 = generate events
//   tick      : one-cycle game-tick strobe
//   ack       : consumer accepts the pending event
//   evt_valid : event pending
//   evt_lane  : lane of the pending event, stable while evt_valid = 1
//   evt_count : number of acknowledged events, wraps 255 -> 0
// modport master : the generator (drives evt_*)
// modport slave  : the consumer / stimulus side (drives rnd, enable, tick, ack)
interface rand_event_gen_if #(
    parameter int unsigned POS_W = 3
);
    logic [7:0]       rnd;
    logic             enable;
    logic             tick;
    logic             ack;
    logic             evt_valid;
    logic [POS_W-1:0] evt_lane;
    logic [7:0]       evt_count;

    modport master (
        input  rnd,
        input  enable,
        input  tick,
        input  ack,
        output evt_valid,
        output evt_lane,
        output evt_count
    );

    modport slave (
        output rnd,
        output enable,
        output tick,
        output ack,
        input  evt_valid,
        input  evt_lane,
        input  evt_count
    );
endinterface

// File: rtl/rand_event_gen.sv
// rand_event_gen: turns a free-running 8-bit random stream into game events.
// After a random gap of game ticks, a random lane in 0..NUM_LANES-1 is chosen
// and held on a valid/ack handshake until the consumer takes it.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : rand_event_gen_if.master (rnd, enable, tick, ack in;
//          evt_valid, evt_lane, evt_count out, all registered)
module rand_event_gen #(
    parameter int unsigned NUM_LANES = 6,
    parameter int unsigned POS_W     = 3,
    parameter int unsigned MIN_GAP   = 4,
    parameter int unsigned GAP_BITS  = 3,
    parameter int unsigned MAX_TRIES = 4,
    parameter int unsigned NO_REPEAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    rand_event_gen_if.master  bus
);

    localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    // Elaboration-time sanity checks on the parameter set.
    if (NUM_LANES < 2 || NUM_LANES > (1 << POS_W)) begin : g_bad_lanes
        $error("rand_event_gen: NUM_LANES must be in 2..2**POS_W");
    end
    if (MIN_GAP < 1 || (MIN_GAP + (1 << GAP_BITS) - 1) > 255) begin : g_bad_gap
        $error("rand_event_gen: gap range must fit in 1..255");
    end
    if (MAX_TRIES < 1) begin : g_bad_tries
        $error("rand_event_gen: MAX_TRIES must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_PICK = 3'd3,
        ST_PEND = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         gap_q, gap_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [POS_W-1:0]   last_q, last_d;
    logic               have_last_q, have_last_d;
    logic               valid_q, valid_d;
    logic [POS_W-1:0]   lane_q, lane_d;
    logic [7:0]         count_q, count_d;

    logic [POS_W-1:0]   cand_c;
    logic               accept_c;
    logic               last_try_c;
    logic [POS_W-1:0]   fallback_c;
    logic [POS_W-1:0]   issue_lane_c;
    logic               issue_c;
    logic               rnd_unused_c;

    // Only the low lane bits and the top gap bits of rnd are consumed.
    assign rnd_unused_c = ^bus.rnd;

    // Candidate evaluation for the PICK state.
    always_comb begin
        cand_c     = bus.rnd[POS_W-1:0];
        accept_c   = (32'(cand_c) < NUM_LANES) &&
                     !((NO_REPEAT != 0) && have_last_q && (cand_c == last_q));
        last_try_c = (tries_q == TRY_W'(MAX_TRIES - 1));
        // Deterministic fallback: next lane after the last one, wrapping.
        if (!have_last_q) begin
            fallback_c = '0;
        end else if (last_q == POS_W'(NUM_LANES - 1)) begin
            fallback_c = '0;
        end else begin
            fallback_c = last_q + POS_W'(1);
        end
        issue_lane_c = accept_c ? cand_c : fallback_c;
        issue_c      = (state_q == ST_PICK) && (accept_c || last_try_c);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.enable) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Disable wins over a coincident tick.
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (bus.tick && (gap_q == 8'd1)) begin
                    state_d = ST_PICK;
                end
            end
            ST_PICK: begin
                if (issue_c) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (bus.ack) state_d = bus.enable ? ST_LOAD : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath / output next values.
    always_comb begin
        gap_d       = gap_q;
        tries_d     = tries_q;
        last_d      = last_q;
        have_last_d = have_last_q;
        valid_d     = valid_q;
        lane_d      = lane_q;
        count_d     = count_q;
        unique case (state_q)
            ST_LOAD: begin
                gap_d = 8'(MIN_GAP) + 8'(bus.rnd[7 -: GAP_BITS]);
            end
            ST_WAIT: begin
                if (!bus.enable) begin
                    gap_d = 8'd0;
                end else if (bus.tick) begin
                    gap_d = gap_q - 8'd1;
                    if (gap_q == 8'd1) tries_d = '0;
                end
            end
            ST_PICK: begin
                if (issue_c) begin
                    valid_d     = 1'b1;
                    lane_d      = issue_lane_c;
                    last_d      = issue_lane_c;
                    have_last_d = 1'b1;
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                end
            end
            ST_PEND: begin
                if (bus.ack) begin
                    valid_d = 1'b0;
                    count_d = count_q + 8'd1;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_q       <= 8'd0;
            tries_q     <= '0;
            last_q      <= '0;
            have_last_q <= 1'b0;
            valid_q     <= 1'b0;
            lane_q      <= '0;
            count_q     <= 8'd0;
        end else begin
            gap_q       <= gap_d;
            tries_q     <= tries_d;
            last_q      <= last_d;
            have_last_q <= have_last_d;
            valid_q     <= valid_d;
            lane_q      <= lane_d;
            count_q     <= count_d;
        end
    end

    assign bus.evt_valid = valid_q;
    assign bus.evt_lane  = lane_q;
    assign bus.evt_count = count_q;

endmodule

// File: tb/tb_rand_event_gen.sv
// Directed testbench for rand_event_gen with hand-computed expectations.
module tb_rand_event_gen;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    rand_event_gen_if #(.POS_W(3)) bus ();

    rand_event_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, then sample 1 time unit after the edge.
    task automatic cyc(input logic [7:0] r, input logic e, input logic t, input logic a);
        bus.rnd    = r;
        bus.enable = e;
        bus.tick   = t;
        bus.ack    = a;
        @(posedge clk);
        #1;
    endtask

    // From the LOAD cycle: rnd=0 gives gap 4, four ticks reach PICK.
    task automatic to_pick();
        for (int k = 0; k < 5; k++) cyc(8'h00, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst        = 1'b1;
        bus.rnd    = 8'h00;
        bus.enable = 1'b0;
        bus.tick   = 1'b0;
        bus.ack    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 8'(bus.evt_valid), 8'd0);
        check("rst_lane",  8'(bus.evt_lane),  8'd0);
        check("rst_count", bus.evt_count,     8'd0);
        rst = 1'b0;

        // Gap 5 (rnd=20 in LOAD), lane 2: valid rises 7 edges after LOAD starts.
        cyc(8'h00, 1'b1, 1'b0, 1'b0);
        cyc(8'h20, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(8'h00, 1'b1, 1'b1, 1'b0);
        check("gap_pre_valid", 8'(bus.evt_valid), 8'd0);
        cyc(8'h02, 1'b1, 1'b1, 1'b0);
        check("gap_valid", 8'(bus.evt_valid), 8'd1);
        check("gap_lane",  8'(bus.evt_lane),  8'd2);

        // Handshake stall: ticks and changing rnd must not disturb the event.
        for (int i = 0; i < 10; i++) begin
            cyc(8'(i * 37 + 1), 1'b1, 1'b1, 1'b0);
            check("stall_valid", 8'(bus.evt_valid), 8'd1);
            check("stall_lane",  8'(bus.evt_lane),  8'd2);
        end
        check("stall_count", bus.evt_count, 8'd0);
        cyc(8'h00, 1'b1, 1'b1, 1'b1);
        check("ack_valid", 8'(bus.evt_valid), 8'd0);
        check("ack_count", bus.evt_count,     8'd1);
        // Next cycle must be LOAD: rnd=E0 gives gap 11.
        cyc(8'hE0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cyc(8'h00, 1'b1, 1'b1, 1'b0);
        check("load_gap11_valid", 8'(bus.evt_valid), 8'd0);
        cyc(8'h00, 1'b1, 1'b1, 1'b0);
        check("load_pick_valid", 8'(bus.evt_valid), 8'd0);

        // Rejection: 7 and 6 out of range, 3 accepted on third PICK cycle.
        cyc(8'h07, 1'b1, 1'b1, 1'b0);
        check("rej1_valid", 8'(bus.evt_valid), 8'd0);
        cyc(8'h06, 1'b1, 1'b1, 1'b0);
        check("rej2_valid", 8'(bus.evt_valid), 8'd0);
        cyc(8'h03, 1'b1, 1'b1, 1'b0);
        check("rej_valid", 8'(bus.evt_valid), 8'd1);
        check("rej_lane",  8'(bus.evt_lane),  8'd3);

        // No-repeat fallback from last lane 3 gives lane 4 after 4 PICK cycles.
        cyc(8'h00, 1'b1, 1'b1, 1'b1);
        check("fb3_count", bus.evt_count, 8'd2);
        to_pick();
        for (int i = 0; i < 3; i++) cyc(8'h03, 1'b1, 1'b1, 1'b0);
        check("fb3_pre_valid", 8'(bus.evt_valid), 8'd0);
        cyc(8'h03, 1'b1, 1'b1, 1'b0);
        check("fb3_valid", 8'(bus.evt_valid), 8'd1);
        check("fb3_lane",  8'(bus.evt_lane),  8'd4);

        // Lane 1 event, count 3 while pending.
        cyc(8'h00, 1'b1, 1'b1, 1'b1);
        to_pick();
        cyc(8'h01, 1'b1, 1'b1, 1'b0);
        check("l1_lane",  8'(bus.evt_lane), 8'd1);
        check("l1_count", bus.evt_count,    8'd3);

        // Asynchronous reset mid-cycle while pending.
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 8'(bus.evt_valid), 8'd0);
        check("arst_count", bus.evt_count,     8'd0);
        check("arst_lane",  8'(bus.evt_lane),  8'd0);
        #2;
        rst = 1'b0;
        bus.enable = 1'b1;
        // LOAD on first edge, gap 4, then 4 rejected picks with have_last=0 -> lane 0.
        for (int i = 0; i < 9; i++) cyc(8'h07, 1'b1, 1'b1, 1'b0);
        check("fbnl_pre_valid", 8'(bus.evt_valid), 8'd0);
        cyc(8'h07, 1'b1, 1'b1, 1'b0);
        check("fbnl_valid", 8'(bus.evt_valid), 8'd1);
        check("fbnl_lane",  8'(bus.evt_lane),  8'd0);

        // Issue lane 5, then fallback wraps to lane 0.
        cyc(8'h00, 1'b1, 1'b1, 1'b1);
        to_pick();
        cyc(8'h05, 1'b1, 1'b1, 1'b0);
        check("l5_lane", 8'(bus.evt_lane), 8'd5);
        cyc(8'h00, 1'b1, 1'b1, 1'b1);
        to_pick();
        for (int i = 0; i < 3; i++) cyc(8'h05, 1'b1, 1'b1, 1'b0);
        check("fb5_pre_valid", 8'(bus.evt_valid), 8'd0);
        cyc(8'h05, 1'b1, 1'b1, 1'b0);
        check("fb5_valid", 8'(bus.evt_valid), 8'd1);
        check("fb5_lane",  8'(bus.evt_lane),  8'd0);
        check("fb5_count", bus.evt_count,     8'd2);

        // Disable while pending: event held, ack returns to IDLE.
        for (int i = 0; i < 3; i++) cyc(8'h00, 1'b0, 1'b1, 1'b0);
        check("pend_dis_valid", 8'(bus.evt_valid), 8'd1);
        check("pend_dis_lane",  8'(bus.evt_lane),  8'd0);
        cyc(8'h01, 1'b0, 1'b1, 1'b1);
        check("pend_dis_ack_valid", 8'(bus.evt_valid), 8'd0);
        check("pend_dis_ack_count", bus.evt_count,     8'd3);
        // From IDLE: LOAD, WAIT x4, PICK -> valid on the 7th edge.
        for (int i = 0; i < 6; i++) cyc(8'h01, 1'b1, 1'b1, 1'b0);
        check("idle_lat_pre_valid", 8'(bus.evt_valid), 8'd0);
        cyc(8'h01, 1'b1, 1'b1, 1'b0);
        check("idle_lat_valid", 8'(bus.evt_valid), 8'd1);
        check("idle_lat_lane",  8'(bus.evt_lane),  8'd1);

        // Disable in WAIT with a coincident tick: no event.
        cyc(8'h01, 1'b1, 1'b1, 1'b1);
        check("wd_count", bus.evt_count, 8'd4);
        cyc(8'h01, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cyc(8'h01, 1'b1, 1'b1, 1'b0);
        cyc(8'h01, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(8'h02, 1'b0, 1'b1, 1'b0);
            check("wd_idle_valid", 8'(bus.evt_valid), 8'd0);
        end
        for (int i = 0; i < 6; i++) cyc(8'h02, 1'b1, 1'b1, 1'b0);
        check("wd_re_pre_valid", 8'(bus.evt_valid), 8'd0);
        cyc(8'h02, 1'b1, 1'b1, 1'b0);
        check("wd_re_valid", 8'(bus.evt_valid), 8'd1);
        check("wd_re_lane",  8'(bus.evt_lane),  8'd2);

        // Drive evt_count up to 255, then wrap to 0.
        for (int i = 0; i < 251; i++) begin
            cyc(8'h00, 1'b1, 1'b1, 1'b1);
            to_pick();
            cyc(8'((i % 2 == 0) ? 1 : 2), 1'b1, 1'b1, 1'b0);
        end
        check("c255_valid", 8'(bus.evt_valid), 8'd1);
        check("c255_lane",  8'(bus.evt_lane),  8'd1);
        check("c255_count", bus.evt_count,     8'd255);
        cyc(8'h00, 1'b1, 1'b1, 1'b1);
        check("wrap_valid", 8'(bus.evt_valid), 8'd0);
        check("wrap_count", bus.evt_count,     8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rand_event_gen.md
Name: rand_event_gen

Overview:
Downstream consumer of the 8-bit pseudo-random stream produced by prng. It turns the free-running random value into game events: a random inter-event gap counted in game ticks, then a random lane index in 0..NUM_LANES-1. Each event is presented on a valid/ack handshake to the game-logic block that spawns objects.

Parameters:
NUM_LANES, 6, number of legal lanes; must be in 2..2^POS_W.
POS_W, 3, width of the lane index.
MIN_GAP, 4, minimum ticks between events; must be ≥1.
GAP_BITS, 3, number of random extra-gap bits (extra 0..2^GAP_BITS-1 ticks); MIN_GAP+2^GAP_BITS-1 ≤ 255.
MAX_TRIES, 4, number of PICK cycles before the deterministic fallback; must be ≥1.
NO_REPEAT, 1, when 1 the same lane is never issued twice in a row.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
rnd  input  8  random value from prng; changes every clk.
enable  input  1  level; 1 = generate events.
tick  input  1  one-cycle game-tick strobe.
ack  input  1  consumer accepts the pending event.
evt_valid  output  1  event pending.
evt_lane  output  POS_W  lane of the pending event; stable while evt_valid=1.
evt_count  output  8  number of acknowledged events; wraps 255->0.

Behaviour:
- Reset (asynchronous, immediate, any state): state=IDLE, evt_valid=0, evt_lane=0, evt_count=0, gap_cnt=0, tries=0, last_lane=0, have_last=0.
- States: IDLE, LOAD, WAIT, PICK, PEND. All outputs are registered.
- IDLE: if enable=1, go to LOAD next cycle. Otherwise stay.
- LOAD (1 cycle): gap_cnt <= MIN_GAP + rnd[7:8-GAP_BITS] (8-bit, zero-extended). Go to WAIT.
- WAIT:
  - If enable=0, go to IDLE. This takes priority over tick; gap_cnt is discarded.
  - Else, on tick=1: gap_cnt decrements. If gap_cnt was 1, go to PICK with tries=0.
  - Cycles with tick=0 do not count.
- PICK (one candidate per cycle): cand = rnd[POS_W-1:0].
  - Accept if cand < NUM_LANES and !(NO_REPEAT && have_last && cand==last_lane).
  - On accept: evt_lane<=cand, last_lane<=cand, have_last<=1, evt_valid<=1; go to PEND.
  - On reject with tries < MAX_TRIES-1: tries++; stay in PICK.
  - On reject with tries == MAX_TRIES-1: fallback lane F = have_last ? (last_lane==NUM_LANES-1 ? 0 : last_lane+1) : 0. Issue F exactly as for an accept in the same cycle.
  - PICK lasts 1..MAX_TRIES cycles. enable and tick are ignored in PICK.
- PEND:
  - evt_valid=1; evt_lane is held.
  - tick is ignored; ticks are not accumulated.
  - enable=0 does not cancel the event; it waits for ack.
  - On ack=1: evt_valid<=0, evt_count++ (wrapping). Next state is LOAD if enable=1, else IDLE.
- ack outside PEND is ignored.
- Latency: evt_valid rises on the clk edge that ends the accepting PICK cycle. With tick held high and the first candidate accepted, evt_valid rises 1 (LOAD) + G (WAIT) + 1 (PICK) cycles after the LOAD cycle begins, where G is the loaded gap.
- rnd is consumed as-is; the block contains no randomness of its own.

Test Plan:
(Bench drives rnd directly for determinism; all cases use default parameters.)
1. Async reset: assert rst mid-cycle while in PEND with evt_count=3. Required: evt_valid=0 and evt_count=0 immediately, without waiting for a clk edge. After release with enable=1, LOAD is entered on the next edge.
2. Gap and lane: enable=1, rnd=8'h20 in LOAD (extra=1, G=5), tick every cycle, rnd=8'h02 in PICK. Required: evt_valid rises exactly 7 cycles after LOAD starts, with evt_lane=2.
3. Rejection: in PICK, drive rnd=8'h07, then 8'h06, then 8'h03. Required: first two rejected (out of range); lane 3 issued on the third PICK cycle; evt_valid=0 until then.
4. No-repeat and fallback:
   - last_lane=3, rnd=8'h03 for 4 PICK cycles. Required: evt_lane=4 after exactly 4 cycles.
   - Repeat with last_lane=5. Required: evt_lane=0.
   - Repeat with have_last=0 and rnd=8'h07 throughout. Required: evt_lane=0.
5. Handshake stall: keep ack=0 for 10 cycles with ticks running. Required: evt_valid and evt_lane stable, evt_count unchanged. Then pulse ack for 1 cycle. Required: evt_count+1, evt_valid=0 next cycle, state LOAD.
6. Enable control:
   - Drop enable in WAIT with a tick in the same cycle. Required: IDLE, no event.
   - Drop enable in PEND. Required: event held; after ack, state IDLE.
   - evt_count=255 plus one ack. Required: evt_count=0.
